// File: rtl/slave_mem_model.sv
// rtl/slave_mem_model.sv - single-port crossbar slave memory with fixed plus random ack latency
module slave_mem_model #(
  parameter int         ADDR_W    = 32,
  parameter int         DATA_W    = 32,
  parameter int         MEM_DEPTH = 256,
  parameter int         ACK_LAT   = 2,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              slave_req,
  input  logic [ADDR_W-1:0] slave_addr,
  input  logic              slave_cmd,
  input  logic [DATA_W-1:0] slave_wdata,
  output logic              slave_ack,
  output logic [DATA_W-1:0] slave_rdata,
  input  logic              rand_stall_en,
  output logic [15:0]       wr_cnt,
  output logic [15:0]       rd_cnt,
  output logic              proto_err
);

  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q;
  logic                cmd_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [7:0]          lfsr_q;
  logic [15:0]         wr_cnt_q, rd_cnt_q;
  logic                proto_err_q;
  logic [DATA_W-1:0]   mem_q [MEM_DEPTH];

  logic                capture;
  logic [IDX_W-1:0]    idx_in, idx_q, rd_idx;
  logic                rd_is_read;
  logic [CNT_W-1:0]    stall, load_cnt;
  logic                proto_viol;
  logic                lfsr_fb;

  // Word index ignores byte-offset bits below and alias bits above the array size.
  assign idx_in   = slave_addr[OFF_W +: IDX_W];
  assign idx_q    = addr_q[OFF_W +: IDX_W];
  assign stall    = rand_stall_en ? {3'b000, lfsr_q[1:0]} : '0;
  assign load_cnt = CNT_W'(ACK_LAT) + stall;

  // A read entering ACK straight from IDLE must use the live request, otherwise the captured one.
  assign rd_idx     = capture ? idx_in : idx_q;
  assign rd_is_read = capture ? ~slave_cmd : ~cmd_q;

  // Requester must hold req and all request fields steady from capture through ACK.
  assign proto_viol = ((state_q == WAIT) || (state_q == ACK)) &&
                      (!slave_req || (slave_addr != addr_q) ||
                       (slave_cmd != cmd_q) || (slave_wdata != wdata_q));

  // Taps 8,6,5,4 of x^8+x^6+x^5+x^4+1, shifting towards the MSB.
  assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

  // Next-state, wait counter and registered read data selection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    rdata_d = '0;
    case (state_q)
      IDLE: begin
        if (slave_req) begin
          capture = 1'b1;
          cnt_d   = load_cnt;
          state_d = (load_cnt != '0) ? WAIT : ACK;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = ACK;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if ((state_d == ACK) && rd_is_read) begin
      rdata_d = mem_q[rd_idx];
    end
  end

  // FSM state, wait counter and read data registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Request capture at acceptance; later changes by the requester are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      cmd_q   <= 1'b0;
      wdata_q <= '0;
    end else if (capture) begin
      addr_q  <= slave_addr;
      cmd_q   <= slave_cmd;
      wdata_q <= slave_wdata;
    end
  end

  // Free-running stall LFSR, independent of traffic.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_fb};
    end
  end

  // Saturating completion counters and sticky protocol error.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      proto_err_q <= 1'b0;
    end else begin
      if (state_q == ACK) begin
        if (cmd_q && (wr_cnt_q != 16'hFFFF)) begin
          wr_cnt_q <= wr_cnt_q + 16'd1;
        end
        if (!cmd_q && (rd_cnt_q != 16'hFFFF)) begin
          rd_cnt_q <= rd_cnt_q + 16'd1;
        end
      end
      if (proto_viol) begin
        proto_err_q <= 1'b1;
      end
    end
  end

  // Memory write at the edge ending ACK; contents survive reset, but reset blocks the write.
  always_ff @(posedge clk) begin
    if (!reset && (state_q == ACK) && cmd_q) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign slave_ack   = (state_q == ACK);
  assign slave_rdata = rdata_q;
  assign wr_cnt      = wr_cnt_q;
  assign rd_cnt      = rd_cnt_q;
  assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_slave_mem_model.sv
// tb/tb_slave_mem_model.sv - scoreboard bench for slave_mem_model, fixed and random latency
module tb_slave_mem_model;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance with ACK_LAT=2 (directed tests)
  logic        rst2 = 1'b1, req2 = 1'b0, cmd2 = 1'b0, stall2 = 1'b0;
  logic [31:0] addr2 = '0, wdata2 = '0;
  logic        ack2, perr2;
  logic [31:0] rdata2;
  logic [15:0] wrc2, rdc2;

  // Instance with ACK_LAT=0 (random stall traffic)
  logic        rst0 = 1'b1, req0 = 1'b0, cmd0 = 1'b0, stall0 = 1'b0;
  logic [31:0] addr0 = '0, wdata0 = '0;
  logic        ack0, perr0;
  logic [31:0] rdata0;
  logic [15:0] wrc0, rdc0;

  slave_mem_model #(.ACK_LAT(2)) u_dut2 (
    .clk(clk), .reset(rst2), .slave_req(req2), .slave_addr(addr2), .slave_cmd(cmd2),
    .slave_wdata(wdata2), .slave_ack(ack2), .slave_rdata(rdata2), .rand_stall_en(stall2),
    .wr_cnt(wrc2), .rd_cnt(rdc2), .proto_err(perr2)
  );

  slave_mem_model #(.ACK_LAT(0)) u_dut0 (
    .clk(clk), .reset(rst0), .slave_req(req0), .slave_addr(addr0), .slave_cmd(cmd0),
    .slave_wdata(wdata0), .slave_ack(ack0), .slave_rdata(rdata0), .rand_stall_en(stall0),
    .wr_cnt(wrc0), .rd_cnt(rdc0), .proto_err(perr0)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  bit mon_on   = 1'b0;
  logic [3:0] lat_seen = '0;

  typedef struct {
    logic [31:0] rdata;
    int          start;
    int          lmin;
    int          lmax;
  } exp_t;

  exp_t q2[$];
  exp_t q0[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
  endtask

  // Monitor for ACK_LAT=2 instance
  always @(negedge clk) begin : mon2
    exp_t e;
    int   d;
    if (mon_on) begin
      if (ack2 === 1'b1) begin
        if (q2.size() == 0) begin
          chk("d2_unexpected_ack", 1, 0);
        end else begin
          e = q2.pop_front();
          d = cyc - e.start + 1;
          chk("d2_rdata", rdata2, e.rdata);
          chk_range("d2_latency", d, e.lmin, e.lmax);
        end
      end else begin
        chk("d2_rdata_zero_outside_ack", rdata2, 0);
      end
    end
  end

  // Monitor for ACK_LAT=0 instance
  always @(negedge clk) begin : mon0
    exp_t e;
    int   d;
    if (mon_on) begin
      if (ack0 === 1'b1) begin
        if (q0.size() == 0) begin
          chk("d0_unexpected_ack", 1, 0);
        end else begin
          e = q0.pop_front();
          d = cyc - e.start + 1;
          chk("d0_rdata", rdata0, e.rdata);
          chk_range("d0_latency", d, e.lmin, e.lmax);
          if (d >= 1 && d <= 4) lat_seen[d-1] = 1'b1;
        end
      end else begin
        chk("d0_rdata_zero_outside_ack", rdata0, 0);
      end
    end
  end

  // One transaction; returns after the edge ending ACK, so a following call is back-to-back.
  task automatic txn(input bit use_d0, input bit cmd, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [31:0] exp_rd,
                     input int lmin, input int lmax, input bit drop);
    exp_t e;
    int   t;
    if (use_d0) begin
      req0 = 1'b1; cmd0 = cmd; addr0 = addr; wdata0 = wd;
    end else begin
      req2 = 1'b1; cmd2 = cmd; addr2 = addr; wdata2 = wd;
    end
    @(posedge clk); #1;
    e.rdata = cmd ? 32'h0 : exp_rd;
    e.start = cyc;
    e.lmin  = lmin;
    e.lmax  = lmax;
    if (use_d0) q0.push_back(e); else q2.push_back(e);
    if (drop) begin
      if (use_d0) req0 = 1'b0; else req2 = 1'b0;
    end
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (((use_d0 ? ack0 : ack2) !== 1'b1) && t < 40);
    if (t >= 40) chk("ack_timeout", 0, 1);
    @(posedge clk); #1;
    if (use_d0) req0 = 1'b0; else req2 = 1'b0;
  endtask

  logic [31:0] ref_mem [256];
  bit          written [256];

  initial begin
    int          nw, nr, idx, gap;
    bit          c;
    logic [31:0] a, wd;

    repeat (3) @(posedge clk);
    #1;
    rst2 = 1'b0;
    rst0 = 1'b0;
    @(negedge clk);
    chk("rst_ack2", ack2, 0);
    chk("rst_rdata2", rdata2, 0);
    chk("rst_wrcnt2", wrc2, 0);
    chk("rst_rdcnt2", rdc2, 0);
    chk("rst_perr2", perr2, 0);
    chk("rst_ack0", ack0, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_perr0", perr0, 0);
    mon_on = 1'b1;
    @(posedge clk); #1;

    // Basic write then read, fixed latency 3
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 3, 3, 0);
    chk("wr_cnt_after_write", wrc2, 1);
    txn(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 3, 3, 0);
    chk("rd_cnt_after_read", rdc2, 1);

    // Address aliasing: 0x400 wraps onto word 0
    txn(0, 1'b1, 32'h000, 32'h1, 32'h0, 3, 3, 0);
    txn(0, 1'b0, 32'h400, 32'h0, 32'h1, 3, 3, 0);

    // Reset during WAIT abandons the write
    txn(0, 1'b1, 32'h20, 32'h5, 32'h0, 3, 3, 0);
    req2 = 1'b1; cmd2 = 1'b1; addr2 = 32'h20; wdata2 = 32'h77;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst2 = 1'b1;
    @(posedge clk); #1;
    rst2 = 1'b0;
    req2 = 1'b0;
    repeat (6) @(negedge clk);
    chk("wr_cnt_after_reset", wrc2, 0);
    chk("rd_cnt_after_reset", rdc2, 0);
    chk("perr_after_reset", perr2, 0);
    @(posedge clk); #1;
    txn(0, 1'b0, 32'h20, 32'h0, 32'h5, 3, 3, 0);

    // Requester drops req in WAIT: sticky error, still exactly one ack
    txn(0, 1'b1, 32'h30, 32'hCAFE, 32'h0, 3, 3, 1);
    @(negedge clk);
    chk("perr_set", perr2, 1);
    repeat (10) @(negedge clk);
    chk("perr_sticky", perr2, 1);
    @(posedge clk); #1;
    txn(0, 1'b0, 32'h30, 32'h0, 32'hCAFE, 3, 3, 0);
    chk("wr_cnt_final2", wrc2, 1);
    chk("rd_cnt_final2", rdc2, 2);

    // Random back-to-back traffic with stall enabled, ACK_LAT=0
    stall0 = 1'b1;
    nw = 0;
    nr = 0;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = '0;
      written[i] = 1'b0;
    end
    for (int i = 0; i < 1000; i++) begin
      c   = 1'($urandom_range(0, 1));
      a   = $urandom & 32'h0000_0FFF;
      wd  = $urandom;
      idx = int'((a / 4) % 256);
      if (!c && !written[idx]) c = 1'b1;
      txn(1, c, a, wd, ref_mem[idx], 1, 4, 0);
      if (c) begin
        ref_mem[idx] = wd;
        written[idx] = 1'b1;
        nw++;
      end else begin
        nr++;
      end
      if ($urandom_range(0, 3) == 0) begin
        gap = $urandom_range(1, 3);
        repeat (gap) begin
          @(posedge clk); #1;
        end
      end
    end
    @(negedge clk);
    chk("rand_wr_cnt", wrc0, nw);
    chk("rand_rd_cnt", rdc0, nr);
    chk("rand_perr", perr0, 0);
    chk("rand_all_latencies_seen", lat_seen, 4'hF);

    repeat (4) @(negedge clk);
    chk("q2_drained", q2.size(), 0);
    chk("q0_drained", q0.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/slave_mem_model.md
SLAVE_MEM_MODEL -- requirements
Module: slave_mem_model

Interface
REQ-001 Parameter ADDR_W, default 32: request address width.
REQ-002 Parameter DATA_W, default 32: data width, multiple of 8.
REQ-003 Parameter MEM_DEPTH, default 256: number of DATA_W words, power of two.
REQ-004 Parameter ACK_LAT, default 2, range 0..15: fixed wait cycles before ack.
REQ-005 Parameter LFSR_SEED, default 8'hA5, nonzero: reset value of stall LFSR.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 slave_req  in  1  request; held with addr/cmd/wdata stable until ack.
REQ-009 slave_addr  in  ADDR_W  byte address.
REQ-010 slave_cmd  in  1  1 = write, 0 = read.
REQ-011 slave_wdata  in  DATA_W  write data.
REQ-012 slave_ack  out  1  one-cycle completion pulse.
REQ-013 slave_rdata  out  DATA_W  read data, valid only while slave_ack = 1.
REQ-014 rand_stall_en  in  1  enables LFSR-driven extra wait cycles.
REQ-015 wr_cnt  out  16  completed writes, saturating.
REQ-016 rd_cnt  out  16  completed reads, saturating.
REQ-017 proto_err  out  1  sticky requester protocol violation flag.

Function
REQ-018 Block SHALL be a synthesizable single-port slave endpoint for one crossbar slave port, storing MEM_DEPTH words.
REQ-019 Word index SHALL be slave_addr[log2(DATA_W/8) +: log2(MEM_DEPTH)]; lower byte-offset bits and upper bits ignored (aliasing wraps).
REQ-020 FSM states SHALL be IDLE, WAIT, ACK.
REQ-021 IDLE: on slave_req = 1, capture addr/cmd/wdata, load wait counter = ACK_LAT + (rand_stall_en ? lfsr[1:0] : 0), go to WAIT if counter > 0 else ACK.
REQ-022 WAIT: decrement counter each cycle; on transition from 1 to 0 go to ACK.
REQ-023 ACK: slave_ack = 1 for exactly one cycle, then IDLE unconditionally.
REQ-024 Latency SHALL be: req first sampled in IDLE at edge N -> slave_ack high in cycle N+1+total wait.
REQ-025 ACK_LAT = 0 without stall: ack in cycle immediately after req sampled; max throughput one transaction per 2 cycles.
REQ-026 Write: memory word at captured index updated with captured wdata at edge ending ACK cycle; slave_rdata = 0 in that cycle.
REQ-027 Read: slave_rdata = mem[captured index] registered, valid in ACK cycle; reflects any write completed in a previous transaction.
REQ-028 slave_rdata SHALL be 0 whenever slave_ack = 0.
REQ-029 LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1, advances every cycle regardless of traffic.
REQ-030 wr_cnt/rd_cnt SHALL increment at edge ending ACK cycle per cmd; hold at 16'hFFFF.
REQ-031 proto_err SHALL set when, in WAIT or ACK, slave_req = 0 or addr/cmd/wdata differ from captured values; transaction still completes with captured values.
REQ-032 proto_err SHALL remain set until reset.
REQ-033 slave_req sampled high in the cycle after ACK SHALL start a new transaction (back-to-back).

Reset
REQ-034 On reset = 1 at an edge: state IDLE, slave_ack 0, slave_rdata 0, wr_cnt 0, rd_cnt 0, proto_err 0, LFSR = LFSR_SEED.
REQ-035 Memory contents SHALL NOT be cleared by reset.
REQ-036 Reset during WAIT or ACK SHALL abandon the transaction: no memory write, no counter increment, no ack after reset.
REQ-037 Reset SHALL take priority over all other events in the same cycle.

Verification
REQ-038 ACK_LAT=2, stall off: write 0xDEADBEEF to addr 0x10 -> ack exactly 3 cycles after req sampled; wr_cnt = 1.
REQ-039 Then read addr 0x10 -> ack 3 cycles later with slave_rdata = 0xDEADBEEF; rd_cnt = 1; rdata 0 outside ack.
REQ-040 MEM_DEPTH=256, DATA_W=32: write 0x1 to addr 0x000, read addr 0x400 -> rdata = 0x1 (alias wrap).
REQ-041 Drop slave_req in WAIT cycle -> proto_err = 1 and stays 1; ack still issued once; no further ack.
REQ-042 Assert reset in WAIT of write to addr 0x20 (prior content 0x5) -> no ack, wr_cnt = 0; subsequent read of 0x20 returns 0x5.
REQ-043 ACK_LAT=0, rand_stall_en=1, 1000 random back-to-back transactions -> ack delay always in 1..4 cycles, reads match reference model, counters match issued counts.
